// File: rtl/rs_intlv_blk_sched.sv
// rs_intlv_blk_sched
//   Block-framing scheduler placed in front of rs_interleaver_xpm. It cuts an
//   arbitrary source symbol stream into exact TOT = D*N symbol blocks. A partial
//   block is padded with FILL symbols when the source ends a frame (s_last) or
//   when flush_req is pulsed. New blocks start only while en is high. Once a
//   block has started it always runs to completion, so the interleaver never
//   sees a torn block.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
//   both high. s_ready may depend combinationally on m_ready. m_* are held
//   stable while m_valid & !m_ready.
//
// Ports
//   clk, rst_n        core clock; asynchronous active-low reset
//   en                1 = new blocks may start
//   flush_req         pulse: pad out the current partial block
//   s_valid/s_ready   source handshake; s_data symbol, s_last end-of-frame
//   m_valid/m_ready   handshake towards the interleaver; m_data symbol
//   m_block_start     m_data is index 0 of a block
//   m_block_last      m_data is index TOT-1 of a block
//   m_fill            m_data is a pad symbol
//   busy              FSM not idle, or output register occupied
//   blk_cnt           completed blocks (wraps)
//   pad_cnt           pad symbols emitted (saturates)
module rs_intlv_blk_sched #(
    parameter int            D    = 8,
    parameter int            N    = 7,
    parameter int            W    = 8,
    parameter logic [W-1:0]  FILL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush_req,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready,
    output logic         m_block_start,
    output logic         m_block_last,
    output logic         m_fill,
    output logic         busy,
    output logic [31:0]  blk_cnt,
    output logic [15:0]  pad_cnt
);

    localparam int            TOT      = D * N;
    localparam int            IW       = (TOT > 1) ? $clog2(TOT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TOT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] sym_idx;
    logic          run;       // low during and for one cycle after reset
    logic          load;      // output register can take a new symbol
    logic          s_fire;
    logic          pad_load;
    logic          out_load;
    logic          idx_last;

    always_comb begin
        load     = !m_valid || m_ready;
        idx_last = (sym_idx == LAST_IDX);
        s_ready  = 1'b0;
        case (state)
            ST_IDLE: s_ready = run && en && load;
            ST_FILL: s_ready = load;
            default: s_ready = 1'b0;
        endcase
        s_fire   = s_valid && s_ready;
        pad_load = (state == ST_PAD) && load;
        out_load = s_fire || pad_load;
    end

    // In ST_FILL sym_idx is never 0, so a flush there always has data to pad.
    // A symbol accepted together with flush_req is taken first; if it closes
    // the block the flush has nothing left to do.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_fire) begin
                    if (idx_last)    state_nxt = ST_IDLE;
                    else if (s_last) state_nxt = ST_PAD;
                    else             state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_fire) begin
                    if (idx_last)                    state_nxt = ST_IDLE;
                    else if (s_last || flush_req)    state_nxt = ST_PAD;
                end else if (flush_req) begin
                    state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                if (load && idx_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sym_idx       <= '0;
            run           <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_block_start <= 1'b0;
            m_block_last  <= 1'b0;
            m_fill        <= 1'b0;
            blk_cnt       <= '0;
            pad_cnt       <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (out_load) begin
                m_valid       <= 1'b1;
                m_data        <= pad_load ? FILL : s_data;
                m_fill        <= pad_load;
                m_block_start <= (sym_idx == '0);
                m_block_last  <= idx_last;
                sym_idx       <= idx_last ? '0 : sym_idx + 1'b1;
                if (idx_last) blk_cnt <= blk_cnt + 32'd1;
                if (pad_load && pad_cnt != 16'hFFFF) pad_cnt <= pad_cnt + 16'd1;
            end else if (load) begin
                m_valid       <= 1'b0;
                m_block_start <= 1'b0;
                m_block_last  <= 1'b0;
                m_fill        <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE) || m_valid;

endmodule

// File: tb/tb_rs_intlv_blk_sched.sv
// Bench for rs_intlv_blk_sched: directed sequences, a block-position model
// that predicts the output stream into an expected queue, and literal checks
// on the counters at the end of each sequence.
module tb_rs_intlv_blk_sched;

  localparam int D = 8;
  localparam int N = 7;
  localparam int W = 8;
  localparam logic [W-1:0] FILL_V = 8'h00;
  localparam int TOT = D * N;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         flush_req;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic         m_block_start;
  logic         m_block_last;
  logic         m_fill;
  logic         busy;
  logic [31:0]  blk_cnt;
  logic [15:0]  pad_cnt;

  rs_intlv_blk_sched #(.D(D), .N(N), .W(W), .FILL(FILL_V)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .flush_req     (flush_req),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .m_block_start (m_block_start),
    .m_block_last  (m_block_last),
    .m_fill        (m_fill),
    .busy          (busy),
    .blk_cnt       (blk_cnt),
    .pad_cnt       (pad_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Entry: {data, block_start, block_last, fill}
  logic [W+2:0] exp_q[$];
  int           pos       = 0;  // index the next symbol takes within its block
  int           pads_out  = 0;  // predicted pads not yet seen on m_*
  int           mblk      = 0;
  int           mpad      = 0;
  int           fill_seen = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_start, prev_last, prev_fill;
  logic [W+2:0] e;

  task automatic push_pads();
    while (pos != 0) begin
      exp_q.push_back({FILL_V, 1'b0, (pos == TOT - 1), 1'b1});
      pads_out++;
      if (mpad != 65535) mpad++;
      pos++;
      if (pos == TOT) begin
        pos = 0;
        mblk++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pads_out >= 2) chk("s_ready_during_pad", 32'(s_ready), 32'd0);
      if (!en && pos == 0) chk("s_ready_en_low", 32'(s_ready), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data",  32'(m_data), 32'(prev_data));
        chk("stall_start", 32'(m_block_start), 32'(prev_start));
        chk("stall_last",  32'(m_block_last), 32'(prev_last));
        chk("stall_fill",  32'(m_fill), 32'(prev_fill));
      end
      if (m_valid && m_ready) begin
        if (m_fill) fill_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0h with empty expected queue at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("m_data",        32'(m_data), 32'(e[W+2:3]));
          chk("m_block_start", 32'(m_block_start), 32'(e[2]));
          chk("m_block_last",  32'(m_block_last), 32'(e[1]));
          chk("m_fill",        32'(m_fill), 32'(e[0]));
          if (e[0]) pads_out--;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_start = m_block_start;
      prev_last  = m_block_last;
      prev_fill  = m_fill;
      if (s_valid && s_ready) begin
        automatic int pos_before = pos;
        exp_q.push_back({s_data, (pos == 0), (pos == TOT - 1), 1'b0});
        pos++;
        if (pos == TOT) begin
          pos = 0;
          mblk++;
        end
        if (s_last && pos != 0) push_pads();
        else if (flush_req && pos_before != 0 && pos != 0) push_pads();
      end else if (flush_req && pos != 0) begin
        push_pads();
      end
    end
  end

  // ---------------- m_ready driver ----------------
  int mode = 0;  // 0: always ready, 1: toggle every cycle
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) m_ready = ~m_ready;
      else           m_ready = 1'b1;
    end
  end

  // ---------------- source driver tasks ----------------
  logic [7:0] lfsr = 8'h01;

  task automatic send_sym(input logic [W-1:0] d, input logic last, input logic fl);
    int waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    flush_req = fl;
    while (!acc && waited <= 300) begin
      @(negedge clk);
      if (s_ready) acc = 1'b1;
      else waited++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: symbol %0h not accepted within 300 cycles", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic send_n(input int n, input int last_at, input int flush_at);
    for (int i = 1; i <= n; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      send_sym(lfsr, (i == last_at), (i == flush_at));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected symbols still queued", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag, input int exp_blk, input int exp_pad);
    chk({tag, "_blk_cnt"}, blk_cnt, 32'(exp_blk));
    chk({tag, "_pad_cnt"}, 32'(pad_cnt), 32'(exp_pad));
    chk({tag, "_blk_model"}, blk_cnt, 32'(mblk));
    chk({tag, "_pad_model"}, 32'(pad_cnt), 32'(mpad));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_block_start"}, 32'(m_block_start), 32'd0);
    chk({tag, "_m_block_last"}, 32'(m_block_last), 32'd0);
    chk({tag, "_m_fill"}, 32'(m_fill), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_blk_cnt"}, blk_cnt, 32'd0);
    chk({tag, "_pad_cnt"}, 32'(pad_cnt), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    flush_req = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_en_low_s_ready", 32'(s_ready), 32'd0);
    en = 1'b1;

    // Full block of data, no end-of-frame.
    send_n(TOT, 0, 0);
    drain();
    chk_counters("t1", 1, 0);

    // End-of-frame on the 20th symbol: 36 pads finish the block.
    fill_seen = 0;
    send_n(20, 20, 0);
    drain();
    chk("t2_fill_seen", 32'(fill_seen), 32'd36);
    chk_counters("t2", 2, 36);

    // End-of-frame exactly on the last index: no padding.
    send_n(TOT, TOT, 0);
    drain();
    chk("t3_idle_busy", 32'(busy), 32'd0);
    chk_counters("t3", 3, 36);

    // Downstream stalls on alternate cycles across two blocks.
    mode = 1;
    send_n(2 * TOT, 0, 0);
    drain();
    mode = 0;
    @(posedge clk);
    #1;
    chk_counters("t4", 5, 36);

    // Flush together with the symbol at index 10: 45 pads follow.
    send_n(11, 0, 11);
    drain();
    chk_counters("t5", 6, 81);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_idle_flush_m_valid", 32'(m_valid), 32'd0);
    chk("t5_idle_flush_busy", 32'(busy), 32'd0);
    chk_counters("t5b", 6, 81);

    // en dropped mid-block: block completes, then no new block starts.
    send_n(30, 0, 0);
    en = 1'b0;
    send_n(TOT - 30, 0, 0);
    s_valid = 1'b1;
    s_data = 8'h5A;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_s_ready_held", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    drain();
    chk_counters("t6", 7, 81);
    en = 1'b1;

    // Reset asserted while padding.
    send_n(5, 5, 0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t7_async");
    exp_q.delete();
    pos = 0;
    pads_out = 0;
    mblk = 0;
    mpad = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_n(TOT, 0, 0);
    drain();
    chk_counters("t7", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
